multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Main sequencer for the multicycle RV32I-subset core.
- Walks each instruction through fetch/decode/execute/memory/writeback and drives the datapath's mux selects, write enables and the 2-bit ALUOp consumed by the ALU decoder.
- Supports lw, sw, R-type, I-type ALU, jal, beq; stalls on a shared instruction/data memory via a ready handshake.

Parameters:
- RESET_STATE, FETCH, state entered on reset.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- op  in  7  instruction opcode, instr[6:0], from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current access this cycle.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0=PC, 1=ALU result register.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register and old-PC enable.
- result_src  out  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult.
- alu_src_a  out  2  SrcA: 00=PC, 01=OldPC, 10=RD1.
- alu_src_b  out  2  SrcB: 00=RD2, 01=ImmExt, 10=constant 4.
- alu_op  out  2  00=add, 01=subtract/compare, 10=funct-decoded.
- imm_src  out  2  immediate format: 00=I, 01=S, 10=B, 11=J.
- reg_write  out  1  register file write enable.
- instr_done  out  1  one-cycle pulse when the instruction retires.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset (async assert): state<=FETCH. While rst=1, pc_write, ir_write, mem_write, reg_write and instr_done are forced 0; all other outputs take FETCH values.
- Outputs are combinational from state plus mem_ready/zero. There are no registered outputs.
- Internal signals: pc_update and branch. pc_write = pc_update | (branch & zero).
- imm_src is decoded combinationally from op in every state:
  - lw/I-ALU -> 00
  - sw -> 01
  - beq -> 10
  - jal -> 11
  - other -> 00
- Unlisted outputs are 0 in every state.
- FETCH(0): adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write and pc_update asserted only when mem_ready=1.
  - Next state: DECODE if mem_ready, else FETCH.
- DECODE(1): alu_src_a=01, alu_src_b=01, alu_op=00 (branch target precompute). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other -> FETCH, with instr_done=1 (illegal opcode treated as NOP).
- MEMADR(2): alu_src_a=10, alu_src_b=01, alu_op=00. Next: MEMREAD if op=lw, else MEMWRITE.
- MEMREAD(3): adr_src=1. Holds until mem_ready=1, then MEMWB.
- MEMWB(4): result_src=01, reg_write=1, instr_done=1. Next: FETCH.
- MEMWRITE(5): adr_src=1, mem_write=1 held until mem_ready=1. On the ready cycle instr_done=1. Next: FETCH.
- EXECUTER(6): alu_src_a=10, alu_src_b=00, alu_op=10. Next: ALUWB.
- EXECUTEI(7): alu_src_a=10, alu_src_b=01, alu_op=10. Next: ALUWB.
- ALUWB(8): result_src=00, reg_write=1, instr_done=1. Next: FETCH.
- JAL(9): alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1. Next: ALUWB (writes rd=PC+4).
- BEQ(10): alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, instr_done=1. Next: FETCH.
- Latencies with mem_ready tied high:
  - lw = 5 cycles
  - sw, R, I, jal = 4 cycles
  - beq = 3 cycles
- Each memory wait cycle adds exactly 1.
- Reset mid-instruction: state returns to FETCH immediately. No partial write enable may be seen after rst rises, even for a memory access in progress.
- Unused state encodings (11–15) -> next state FETCH, all enables 0.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum (4-bit, values above)
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ)
  - ALUOp, result_src, alu_src_a/b and imm_src encodings
- One sub-module: imm_src_decoder (op -> imm_src), also reused by the single-cycle core.
- The main FSM keeps its state register and next-state/output logic in one module.

Test Plan:
- Reset: rst pulsed asynchronously mid-MEMWRITE with mem_write=1 -> mem_write drops the same cycle; state_dbg=0 after release.
- R-type add: op=0110011, mem_ready=1 -> state sequence 0,1,6,8,0. alu_op=10 in state 6; reg_write=1 and instr_done=1 only in state 8.
- lw with 2 wait cycles: op=0000011, mem_ready low 2 cycles in MEMREAD -> sequence 0,1,2,3,3,3,4,0 (7 cycles). adr_src=1 throughout MEMREAD; result_src=01 in MEMWB.
- beq taken/not taken: zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0. Both return to FETCH after 3 cycles; imm_src=10 throughout.
- jal: op=1101111 -> sequence 0,1,9,8,0. pc_write=1 in JAL; alu_src_b=10 in JAL; imm_src=11.
- Illegal opcode 0000000 -> 0,1,0 with no reg_write/mem_write; instr_done pulses in DECODE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle and single-cycle RV32I-subset control paths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Raw per-state control word; enables are gated by reset in the top.
    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer and the datapath.
// Latency: n/a (wires only).
// Backpressure: mem_ready from the shared memory stalls the sequencer.
interface multicycle_control_fsm_if;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       reg_write;
    logic       instr_done;
    logic [3:0] state_dbg;

    modport master (
        input  op, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, reg_write,
               instr_done, state_dbg
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, reg_write,
               instr_done, state_dbg
    );
endinterface

// File: rtl/imm_src_decoder.sv
// Maps an opcode to its immediate format select.
// Latency: combinational.
// Backpressure: none.
module imm_src_decoder
    import cpu_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main sequencer: fetch/decode/execute/memory/writeback control for the multicycle core.
// Latency: beq 3, sw/R/I/jal 4, lw 5 cycles; outputs combinational from state.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready.
module multicycle_control_fsm
    import cpu_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_control_fsm_if.master ctrl
);

    state_t state_q;
    state_t state_d;
    ctrl_t  c;

    imm_src_decoder u_imm_src_decoder (
        .op      (ctrl.op),
        .imm_src (ctrl.imm_src)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = ctrl.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (ctrl.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (ctrl.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = ctrl.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = ctrl.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        c = '0;
        case (state_q)
            S_FETCH: begin
                c.adr_src    = 1'b0;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALURESULT;
                c.ir_write   = ctrl.mem_ready;
                c.pc_update  = ctrl.mem_ready;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
                // Unknown opcodes retire here as a NOP.
                case (ctrl.op)
                    OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: c.instr_done = 1'b0;
                    default:                                  c.instr_done = 1'b1;
                endcase
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src    = 1'b1;
                c.mem_write  = 1'b1;
                c.instr_done = ctrl.mem_ready;
            end
            S_EXECUTER: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALUOUT;
                c.pc_update  = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = SRCA_RD1;
                c.alu_src_b  = SRCB_RD2;
                c.alu_op     = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
    end

    // Enables are masked by rst directly so an access in flight cannot leak a strobe.
    assign ctrl.pc_write   = ~rst & (c.pc_update | (c.branch & ctrl.zero));
    assign ctrl.mem_write  = ~rst & c.mem_write;
    assign ctrl.ir_write   = ~rst & c.ir_write;
    assign ctrl.reg_write  = ~rst & c.reg_write;
    assign ctrl.instr_done = ~rst & c.instr_done;
    assign ctrl.adr_src    = c.adr_src;
    assign ctrl.result_src = c.result_src;
    assign ctrl.alu_src_a  = c.alu_src_a;
    assign ctrl.alu_src_b  = c.alu_src_b;
    assign ctrl.alu_op     = c.alu_op;
    assign ctrl.state_dbg  = state_q;

endmodule
